// File: rtl/packet_builder.sv
// Frames one message per handshake into a header+payload stream of 32-bit beats.
// Latency: message accepted at edge N, beat 0 valid from edge N+1; one bubble between packets.
// Backpressure: beats hold stable while dataOut_ready is low; msgIn_ready only in IDLE.
module packet_builder #(
    parameter int STREAM_W = 4,
    parameter int MAX_PAY  = 36
) (
    input  logic                    clk,
    input  logic                    reset_b,
    input  logic [0:8*MAX_PAY-1]    msgIn,
    input  logic [STREAM_W-1:0]     msgIn_stream,
    input  logic [5:0]              msgIn_len,
    input  logic                    msgIn_skip,
    input  logic                    msgIn_val,
    output logic                    msgIn_ready,
    output logic [31:0]             dataOut,
    output logic                    dataOut_val,
    input  logic                    dataOut_ready,
    output logic                    dataOut_last,
    output logic                    lenErr
);

    localparam int          NSTREAM = 2**STREAM_W;
    localparam logic [5:0]  MAX_LEN = 6'(MAX_PAY);

    typedef enum logic [1:0] {IDLE, HDR0, HDR1, PAY} state_t;

    state_t                 r_state;
    logic [31:0]            r_seq_tbl [NSTREAM];
    logic [0:8*MAX_PAY-1]   r_pay;
    logic [5:0]             r_len;
    logic [31:0]            r_seq;
    logic [3:0]             r_word;
    logic                   r_in_rdy;
    logic                   r_vld;
    logic                   r_last;
    logic [31:0]            r_dat;
    logic                   r_len_err;

    logic [31:0]            w_seq_new;
    logic [15:0]            w_len16;
    logic [15:0]            w_id16;
    logic                   w_len_ok;
    logic [3:0]             w_last_word;
    logic [3:0]             w_word_idx;
    logic [5:0]             w_bi;
    logic [31:0]            w_word;

    // Header fields and next sequence number for the message offered at the input
    always_comb begin
        w_seq_new   = r_seq_tbl[msgIn_stream] + (msgIn_skip ? 32'd2 : 32'd1);
        w_len16     = 16'(msgIn_len) + 16'd8;
        w_id16      = 16'(msgIn_stream);
        w_len_ok    = (msgIn_len <= MAX_LEN);
        w_last_word = 4'((r_len + 6'd3) >> 2) - 4'd1;
    end

    // Payload word that will be driven next: word 0 when leaving HDR1, else the following word
    always_comb begin
        w_word_idx = (r_state == PAY) ? (r_word + 4'd1) : 4'd0;
        w_word     = 32'h0;
        w_bi       = 6'd0;
        for (int j = 0; j < 4; j++) begin
            w_bi = {w_word_idx, 2'(j)};
            // bytes past the message length are padded with zero
            if (w_bi < r_len) begin
                w_word[31-8*j -: 8] = r_pay[{3'b000, w_bi, 3'b000} +: 8];
            end
        end
    end

    // Control FSM with registered beat outputs and the per-stream sequence table
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            r_state   <= IDLE;
            r_in_rdy  <= 1'b0;
            r_vld     <= 1'b0;
            r_last    <= 1'b0;
            r_dat     <= 32'h0;
            r_len_err <= 1'b0;
            r_len     <= 6'd0;
            r_seq     <= 32'h0;
            r_word    <= 4'd0;
            r_pay     <= '0;
            for (int i = 0; i < NSTREAM; i++) begin
                r_seq_tbl[i] <= 32'h0;
            end
        end else begin
            r_len_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_in_rdy <= 1'b1;
                    if (msgIn_val && r_in_rdy) begin
                        if (w_len_ok) begin
                            r_pay                   <= msgIn;
                            r_len                   <= msgIn_len;
                            r_seq                   <= w_seq_new;
                            r_seq_tbl[msgIn_stream] <= w_seq_new;
                            r_dat    <= {w_len16[7:0], w_len16[15:8], w_id16[7:0], w_id16[15:8]};
                            r_vld    <= 1'b1;
                            r_last   <= 1'b0;
                            r_in_rdy <= 1'b0;
                            r_state  <= HDR0;
                        end else begin
                            // oversize message is consumed and dropped; table untouched
                            r_len_err <= 1'b1;
                        end
                    end
                end
                HDR0: begin
                    if (dataOut_ready) begin
                        r_dat   <= {r_seq[7:0], r_seq[15:8], r_seq[23:16], r_seq[31:24]};
                        r_last  <= (r_len == 6'd0);
                        r_state <= HDR1;
                    end
                end
                HDR1: begin
                    if (dataOut_ready) begin
                        if (r_len == 6'd0) begin
                            r_vld    <= 1'b0;
                            r_last   <= 1'b0;
                            r_dat    <= 32'h0;
                            r_in_rdy <= 1'b1;
                            r_state  <= IDLE;
                        end else begin
                            r_dat   <= w_word;
                            r_last  <= (w_last_word == 4'd0);
                            r_word  <= 4'd0;
                            r_state <= PAY;
                        end
                    end
                end
                PAY: begin
                    if (dataOut_ready) begin
                        if (r_last) begin
                            r_vld    <= 1'b0;
                            r_last   <= 1'b0;
                            r_dat    <= 32'h0;
                            r_in_rdy <= 1'b1;
                            r_state  <= IDLE;
                        end else begin
                            r_word <= r_word + 4'd1;
                            r_dat  <= w_word;
                            r_last <= ((r_word + 4'd1) == w_last_word);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign msgIn_ready  = r_in_rdy;
    assign dataOut      = r_dat;
    assign dataOut_val  = r_vld;
    assign dataOut_last = r_last;
    assign lenErr       = r_len_err;

endmodule
